// File: rtl/io_uart_pkg.sv
// Shared types and constants for the IO-mapped UART transmitter:
// FSM state encoding, default register addresses and status bit positions.
package io_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [15:0] DEF_TXDATA_ADDR = 16'h1000;
  localparam logic [15:0] DEF_STATUS_ADDR = 16'h2000;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_FULL_BIT  = 2;
  localparam int STAT_OVF_BIT   = 3;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with a combinational head output; a push is
// accepted when not full, or when full but a pop happens in the same cycle.
module io_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// IO-mapped UART transmitter: TX data register feeds a FIFO, a status register
// reports {overflow, full, empty, busy}. Define UART_TX_PARITY_EN for even parity.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] TXDATA_ADDR  = DEF_TXDATA_ADDR,
  parameter logic [15:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_tx,
  output logic        busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   din_q, din_d;

  logic          wr_tx, rd_any, rd_stat, ovf_event, bit_end;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_cnt;
  logic [15:0]   status;
  logic          unused_dout;

  assign unused_dout = ^io_dout[15:8];

  // A write to the data register wins over a simultaneous read strobe.
  assign wr_tx     = io_wr && (io_addr == TXDATA_ADDR);
  assign rd_any    = io_rd && !wr_tx;
  assign rd_stat   = rd_any && (io_addr == STATUS_ADDR);
  assign ovf_event = wr_tx && fifo_full && !fifo_pop;
  assign bit_end   = (timer_q == T_LAST);

  assign busy    = (fifo_cnt != '0) || (state_q != ST_IDLE);
  assign uart_tx = tx_q;
  assign io_din  = din_q;

  io_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_tx),
    .pop_i   (fifo_pop),
    .wdata_i (io_dout[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  always_comb begin
    status                 = '0;
    status[STAT_BUSY_BIT]  = busy;
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_OVF_BIT]   = ovf_q;
  end

  // The status read clears overflow, but a new overflow in that cycle wins.
  always_comb begin
    din_d = din_q;
    ovf_d = ovf_q;
    if (rd_stat) begin
      din_d = status;
      ovf_d = 1'b0;
    end else if (rd_any) begin
      din_d = 16'h0000;
    end
    if (ovf_event) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          tx_d     = 1'b0;
          timer_d  = '0;
          bitcnt_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          timer_d = '0;
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // The shift register rotates, so after eight bits it holds the
      // original byte again and its XOR is still the frame's parity.
      ST_DATA: begin
        if (bit_end) begin
          timer_d = '0;
          shreg_d = {shreg_q[0], shreg_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shreg_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
            tx_d     = shreg_q[1];
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          timer_d = '0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          timer_d = '0;
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
      din_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
      din_q    <= din_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a frame-level reference model checked every cycle,
// plus literal spot checks. Honours UART_TX_PARITY_EN like the design.
module tb_io_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] TXA   = 16'h1000;
  localparam logic [15:0] STA   = 16'h2000;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic        clk = 1'b0;
  logic        reset, io_wr, io_rd;
  logic [15:0] io_addr, io_dout, io_din;
  logic        uart_tx, busy;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .TXDATA_ADDR  (TXA),
    .STATUS_ADDR  (STA)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_addr (io_addr),
    .io_dout (io_dout),
    .io_din  (io_din),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, frame-in-flight byte and elapsed cycles.
  logic [7:0]  mq[$];
  bit          m_active = 1'b0;
  int          m_t = 0;
  logic [7:0]  m_byte = 8'h00;
  bit          m_ovf = 1'b0;
  logic [15:0] m_din = 16'h0000;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit          was_act, pop, wr_tx, ovf_ev;
    logic [15:0] stat;
    int          sz;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
      m_din    = 16'h0000;
    end else begin
      sz      = mq.size();
      was_act = m_active;
      stat    = {12'b0, m_ovf, sz == DEPTH, sz == 0, (m_active || sz != 0)};
      wr_tx   = io_wr && (io_addr == TXA);
      pop     = !was_act && (sz != 0);
      if (was_act) begin
        m_t++;
        if (m_t == FLEN) m_active = 1'b0;
      end
      if (pop) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      ovf_ev = 1'b0;
      if (wr_tx) begin
        if (sz < DEPTH || pop) mq.push_back(io_dout[7:0]);
        else ovf_ev = 1'b1;
      end
      if (io_rd && !wr_tx) begin
        m_din = (io_addr == STA) ? stat : 16'h0000;
        if (io_addr == STA) m_ovf = 1'b0;
      end
      if (ovf_ev) m_ovf = 1'b1;
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_line", 16'(uart_tx), 16'(m_active ? frame_bit(m_byte, m_t / CPB) : 1'b1));
      check("busy", 16'(busy), 16'(m_active || mq.size() != 0));
      check("io_din", io_din, m_din);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    io_wr = 1'b1; io_addr = TXA; io_dout = {8'h00, b};
    @(negedge clk);
    io_wr = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    io_rd = 1'b1; io_addr = a;
    @(negedge clk);
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic drain();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 16'(busy), 16'h0000);
  endtask

  logic s_tx   [50];
  logic s_busy [50];

  // Write one byte while idle, then record the line from the pop cycle on.
  task automatic capture(input logic [7:0] b);
    wr(b);
    for (int i = 0; i < 50; i++) begin
      s_tx[i]   = uart_tx;
      s_busy[i] = busy;
      @(negedge clk);
    end
  endtask

  function automatic int zeros();
    int z = 0;
    for (int i = 0; i < 50; i++) if (s_tx[i] == 1'b0) z++;
    return z;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    @(negedge clk); @(negedge clk);
    check("rst_tx", 16'(uart_tx), 16'h0001);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_din", io_din, 16'h0000);
    chk_en = 1'b1;
    reset  = 1'b0;
    idle(2);

    rd(STA);
    check("stat_idle", io_din, 16'h0002);
    rd(16'h3000);
    check("rd_other", io_din, 16'h0000);

    rd(STA);
    io_wr = 1'b1; io_rd = 1'b1; io_addr = TXA; io_dout = 16'h00A5;
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0; io_addr = 16'h0000;
    check("wr_rd_hold", io_din, 16'h0002);
    drain();
    idle(2);

`ifndef UART_TX_PARITY_EN
    capture(8'h55);
    check("f55_pop_idle", 16'(s_tx[0]), 16'h0001);
    check("f55_start_a", 16'(s_tx[1]), 16'h0000);
    check("f55_start_b", 16'(s_tx[4]), 16'h0000);
    check("f55_bit0", 16'(s_tx[5]), 16'h0001);
    check("f55_bit1", 16'(s_tx[9]), 16'h0000);
    check("f55_bit7", 16'(s_tx[36]), 16'h0000);
    check("f55_stop", 16'(s_tx[37]), 16'h0001);
    check("f55_busy_end", 16'(s_busy[40]), 16'h0001);
    check("f55_busy_fall", 16'(s_busy[41]), 16'h0000);
    check("f55_zeros", 16'(zeros()), 16'd20);
`else
    capture(8'h07);
    check("f07_start", 16'(s_tx[1]), 16'h0000);
    check("f07_bit2", 16'(s_tx[13]), 16'h0001);
    check("f07_bit3", 16'(s_tx[17]), 16'h0000);
    check("f07_parity", 16'(s_tx[37]), 16'h0001);
    check("f07_stop", 16'(s_tx[41]), 16'h0001);
    check("f07_busy_end", 16'(s_busy[44]), 16'h0001);
    check("f07_busy_fall", 16'(s_busy[45]), 16'h0000);
    check("f07_zeros", 16'(zeros()), 16'd24);
    idle(2);
    capture(8'h03);
    check("f03_parity", 16'(s_tx[37]), 16'h0000);
    check("f03_parity_end", 16'(s_tx[40]), 16'h0000);
    check("f03_stop", 16'(s_tx[41]), 16'h0001);
    check("f03_zeros", 16'(zeros()), 16'd32);
`endif
    idle(2);

    for (int k = 1; k <= 6; k++) begin
      io_wr = 1'b1; io_addr = TXA; io_dout = 16'(k);
      @(negedge clk);
    end
    io_wr = 1'b0; io_addr = 16'h0000;
    rd(STA);
    check("ovf_set", io_din, 16'h000D);
    rd(STA);
    check("ovf_clear", io_din, 16'h0005);
    drain();
    idle(2);

    wr(8'hA0);
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    idle(FLEN - 3);
    wr(8'hA5);
    rd(STA);
    check("pop_cycle_wr", io_din, 16'h0005);
    drain();
    idle(2);

    wr(8'hF7); wr(8'hB1); wr(8'hB2);
    idle(16);
    check("pre_rst_bit3", 16'(uart_tx), 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_tx", 16'(uart_tx), 16'h0001);
    check("rst_mid_busy", 16'(busy), 16'h0000);
    rd(STA);
    check("rst_mid_stat", io_din, 16'h0002);
    idle(50);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
